mdu: RTL and testbench
======================

# mdu

Multiply/divide unit in the E stage. It is the responder to the decoder's `MDOp`/`MD_start`/`isMDFT` outputs:
- executes `mult`, `multu`, `div` and `divu` over a fixed multi-cycle latency, owning the HI and LO registers;
- serves `mfhi`/`mflo` reads and `mthi`/`mtlo` writes;
- reports `busy` so the hazard unit can stall any `isMDFT` instruction in D.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`
- `clk`  in  1  clock; all state updates on the rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `MDOp`  in  4  operation code (`MD_*`) of the instruction currently in E
- `MD_start`  in  1  high for one cycle when a `mult`/`multu`/`div`/`divu` is in E
- `A`  in  32  forwarded rs value
- `B`  in  32  forwarded rt value
- `busy`  out  1  an operation is in flight
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `MD_out`  out  32  `mfhi` gives HI, `mflo` gives LO, otherwise 0 (combinational)

## Operation
- States:
  - IDLE: `busy`=0, counter=0.
  - RUN: `busy`=1, counter counts down.
- IDLE→RUN: `MD_start`=1 and `MDOp` is one of mult/multu/div/divu.
  - Compute the result from `A`/`B` at that edge into internal temp registers `hi_t` and `lo_t`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
- RUN: decrement each edge. On the edge where the counter reaches 1:
  - copy `hi_t` to HI and `lo_t` to LO;
  - return to IDLE.
- Arithmetic:
  - `mult`: {HI,LO} = signed 64-bit product.
  - `multu`: {HI,LO} = unsigned 64-bit product.
  - `div`: LO = signed quotient, truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - `divu`: unsigned quotient to LO, unsigned remainder to HI.
  - `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B=0): the operation still takes `DIV_CYCLES` cycles; HI and LO are left unchanged at commit.
- `mthi`/`mtlo`: when `MDOp`=MD_mthi/MD_mtlo and `busy`=0, write HI/LO ← `A` at the next edge.
- `MD_start` with a non-md `MDOp`: ignored.
- Ignored while `busy`=1, with a bench assertion firing (the controller must have stalled):
  - `MD_start`;
  - `mthi`/`mtlo`.
- `MD_out` reads the current HI/LO. It does not bypass a pending commit, because the stall guarantees no read occurs while `busy`=1.
- `MDOp`=MD_else (bubble): no effect.

## Timing
- Reset (async assert, any state): `busy`=0, HI=0, LO=0, `MD_out`=0, counter=0, `hi_t`=`lo_t`=0, state IDLE.
  - An in-flight operation is discarded.
  - Release is synchronous to `clk`.
- `MD_start` sampled at edge E0:
  - `busy`=1 from just after E0 through edge E_N, where N = `MULT_CYCLES` or `DIV_CYCLES`;
  - `busy` is high for exactly N cycles;
  - HI/LO take their new values at edge E_N, in the same edge that `busy` falls.
- A new `MD_start` in the cycle right after `busy` falls is accepted; there are no dead cycles.
- `mthi`/`mtlo` latency is 1 edge. An `mfhi` one cycle later reads the new value.
- `busy` is a registered output. The hazard unit uses `MD_start` | `busy` to stall D.

## Structure
- Shared `define.v` holds the MD op codes (4-bit):
  - MD_else=0, MD_mult=1, MD_multu=2, MD_div=3, MD_divu=4;
  - MD_mfhi=5, MD_mflo=6, MD_mthi=7, MD_mtlo=8.
- `define.v` also holds the default cycle counts.
- Single module with no sub-module. The counter, the two-state control and the temp registers are local.
- Product and quotient use behavioural `*`, `/` and `%` on `$signed`/unsigned operands; the multi-cycle delay is modelled by the counter only.

## Test plan
- `mult` A=0xFFFFFFFE(-2), B=3 → `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- `divu` A=100, B=7 → `busy` high for 10 cycles, then LO=14, HI=2; `div` A=-7, B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- `mthi` A=0x12345678, then `mfhi` → `MD_out`=0x12345678 on the cycle after the write; `mflo` → `MD_out`=old LO.
- `mult` started, then a second `MD_start` and an `mtlo` while `busy` → both ignored, the first result commits unchanged, and the assertion fires.
- `div` with B=0 after HI=1, LO=2 → `busy` high for 10 cycles; HI stays 1 and LO stays 2.
- `reset_n` pulled low at cycle 3 of a `div` → `busy`, HI and LO are 0 immediately; after release, a fresh `multu` 0xFFFFFFFF×2 gives HI=1, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MD_* operation codes (4-bit) driven by the decoder into E.
//   - Default busy-cycle counts for multiply and divide.
//   - Two-state control encoding for the unit's sequencer.
package mdu_pkg;

    localparam logic [3:0] MD_else  = 4'd0;
    localparam logic [3:0] MD_mult  = 4'd1;
    localparam logic [3:0] MD_multu = 4'd2;
    localparam logic [3:0] MD_div   = 4'd3;
    localparam logic [3:0] MD_divu  = 4'd4;
    localparam logic [3:0] MD_mfhi  = 4'd5;
    localparam logic [3:0] MD_mflo  = 4'd6;
    localparam logic [3:0] MD_mthi  = 4'd7;
    localparam logic [3:0] MD_mtlo  = 4'd8;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

endpackage

// File: rtl/mdu.sv
// mdu: E-stage multiply/divide unit owning the HI/LO registers.
//   Executes mult/multu/div/divu with a fixed multi-cycle latency, serves
//   mfhi/mflo reads and mthi/mtlo writes, and reports busy to the hazard unit.
// Ports:
//   clk      - clock, all state updates on the rising edge
//   reset_n  - asynchronous active-low reset
//   MDOp     - MD_* operation code of the instruction in E
//   MD_start - one-cycle start strobe for mult/multu/div/divu
//   A, B     - forwarded rs / rt values
//   busy     - an operation is in flight (registered)
//   HI, LO   - architectural HI/LO registers
//   MD_out   - HI for mfhi, LO for mflo, otherwise 0 (combinational)
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDOp,
    input  logic        MD_start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out
);

    localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      hi_t;
    logic [31:0]      lo_t;
    logic             skip_t;     // divide by zero: commit leaves HI/LO untouched

    logic             is_md;
    logic             is_div;
    logic             div_zero;
    logic             div_ovf;
    logic [31:0]      div_b;
    logic [31:0]      sdiv_b;
    logic signed [63:0] prod_s;
    logic [63:0]      prod_u;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic [31:0]      hi_n;
    logic [31:0]      lo_n;
    logic [CNT_W-1:0] cnt_load;

    always_comb begin
        is_md    = (MDOp == MD_mult) || (MDOp == MD_multu) ||
                   (MDOp == MD_div)  || (MDOp == MD_divu);
        is_div   = (MDOp == MD_div) || (MDOp == MD_divu);
        div_zero = (B == '0);
        div_ovf  = (A == 32'h8000_0000) && (B == '1);

        // Substitute a harmless divisor for B=0 (result discarded anyway) and
        // for 0x80000000 / -1, where dividing by +1 yields exactly the
        // required LO=0x80000000, HI=0 without signed overflow.
        div_b  = div_zero ? 32'd1 : B;
        sdiv_b = div_ovf  ? 32'd1 : div_b;

        prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u = {32'b0, A} * {32'b0, B};
        q_s    = $signed(A) / $signed(sdiv_b);
        r_s    = $signed(A) % $signed(sdiv_b);

        hi_n = '0;
        lo_n = '0;
        case (MDOp)
            MD_mult:  {hi_n, lo_n} = prod_s;
            MD_multu: {hi_n, lo_n} = prod_u;
            MD_div: begin
                hi_n = r_s;
                lo_n = q_s;
            end
            MD_divu: begin
                hi_n = A % div_b;
                lo_n = A / div_b;
            end
            default: ;
        endcase

        cnt_load = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi_t   <= '0;
            lo_t   <= '0;
            skip_t <= 1'b0;
            HI     <= '0;
            LO     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (MD_start && is_md) begin
                        state  <= S_RUN;
                        cnt    <= cnt_load;
                        hi_t   <= hi_n;
                        lo_t   <= lo_n;
                        skip_t <= is_div && div_zero;
                    end
                    if (MDOp == MD_mthi) HI <= A;
                    if (MDOp == MD_mtlo) LO <= A;
                end
                default: begin
                    if (cnt == CNT_W'(1)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        if (!skip_t) begin
                            HI <= hi_t;
                            LO <= lo_t;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign busy = (state == S_RUN);

    always_comb begin
        MD_out = '0;
        if (MDOp == MD_mfhi) MD_out = HI;
        else if (MDOp == MD_mflo) MD_out = LO;
    end

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu. Stimulus pushes the expected HI/LO and
// busy length of each operation; a monitor pops and compares when busy falls.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [3:0]  MDOp;
    logic        MD_start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MD_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_viol   = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset_n(reset_n), .MDOp(MDOp), .MD_start(MD_start),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO), .MD_out(MD_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int unsigned ecyc);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cyc = ecyc;
        sb.push_back(e);
        MDOp = op; A = a; B = b; MD_start = 1'b1;
        tick;
        MD_start = 1'b0; MDOp = MD_else;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 64) begin
            tick;
            n++;
        end
        if (busy) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: busy still 1 after %0d cycles, required 0", name, n);
        end
    endtask

    // Monitor: counts busy cycles, compares on the busy falling edge and flags
    // controller protocol violations (start / mthi / mtlo while busy).
    initial begin : monitor
        int   cyc;
        logic prev;
        exp_t e;
        cyc  = 0;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cyc  = 0;
                prev = 1'b0;
            end else begin
                if (busy && (MD_start || MDOp == MD_mthi || MDOp == MD_mtlo)) n_viol++;
                if (busy) begin
                    cyc++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_commit: HI=0x%0h LO=0x%0h with no pending op", HI, LO);
                    end else begin
                        e = sb.pop_front();
                        check("busy_cycles", 64'(cyc), 64'(e.cyc));
                        check("HI", {32'b0, HI}, {32'b0, e.hi});
                        check("LO", {32'b0, LO}, {32'b0, e.lo});
                    end
                    cyc = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        reset_n = 1'b0; MDOp = MD_else; MD_start = 1'b0; A = '0; B = '0;
        repeat (2) tick;
        MDOp = MD_mfhi;
        #1;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_HI", {32'b0, HI}, 64'd0);
        check("reset_LO", {32'b0, LO}, 64'd0);
        check("reset_MD_out", {32'b0, MD_out}, 64'd0);
        MDOp = MD_else;
        tick;
        reset_n = 1'b1;
        tick;

        issue(MD_mult, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
        wait_idle("mult");
        issue(MD_divu, 32'd100, 32'd7, 32'd2, 32'd14, 10);
        wait_idle("divu");
        issue(MD_div, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        wait_idle("div_neg");
        issue(MD_div, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 10);
        wait_idle("div_ovf");

        // mthi then mfhi/mflo reads
        MDOp = MD_mthi; A = 32'h1234_5678;
        tick;
        MDOp = MD_mfhi; A = '0;
        #1 check("mfhi_after_mthi", {32'b0, MD_out}, 64'h1234_5678);
        MDOp = MD_mflo;
        #1 check("mflo_old_LO", {32'b0, MD_out}, 64'h8000_0000);
        MDOp = MD_else;
        #1 check("md_out_else", {32'b0, MD_out}, 64'd0);

        // start and mtlo while busy are ignored; then back-to-back multu
        issue(MD_mult, 32'd7, 32'd6, 32'd0, 32'd42, 5);
        tick;
        MD_start = 1'b1; MDOp = MD_mult; A = 32'd1; B = 32'd1;
        tick;
        MD_start = 1'b0; MDOp = MD_mtlo; A = 32'hDEAD_BEEF;
        tick;
        MDOp = MD_else;
        wait_idle("mult_busy");
        issue(MD_multu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5);
        wait_idle("multu_b2b");
        check("busy_violations", 64'(n_viol), 64'd2);

        // divide by zero leaves HI/LO unchanged
        MDOp = MD_mthi; A = 32'd1;
        tick;
        MDOp = MD_mtlo; A = 32'd2;
        tick;
        issue(MD_div, 32'd5, 32'd0, 32'd1, 32'd2, 10);
        wait_idle("div_zero");

        // async reset in the middle of a div
        issue(MD_div, 32'd100, 32'd3, 32'd1, 32'd33, 10);
        tick;
        tick;
        reset_n = 1'b0;
        #1;
        check("midreset_busy", {63'b0, busy}, 64'd0);
        check("midreset_HI", {32'b0, HI}, 64'd0);
        check("midreset_LO", {32'b0, LO}, 64'd0);
        sb.delete();
        tick;
        reset_n = 1'b1;
        tick;
        issue(MD_multu, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5);
        wait_idle("multu_after_reset");

        repeat (3) tick;
        check("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
